// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: instruction memory port, redirect/halt control and decode handshake.
// The fetch stage is the master; memory and decode together form the slave side.
interface inst_fetch_queue_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        empty;
  logic        full;

  modport master (
    output imem_addr, out_valid, out_pc, out_inst, empty, full,
    input  imem_dout, redirect_valid, redirect_pc, halt_req, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_inst, empty, full,
    output imem_dout, redirect_valid, redirect_pc, halt_req, out_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC and buffers {pc, inst} pairs for decode.
// Optional macro IFQ_PERF_CNT_EN adds fetch and flush performance counters.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  inst_fetch_queue_if.master   bus
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic not_empty;
  logic is_full;
  logic push;
  logic pop;

  assign not_empty = (count_q != '0);
  assign is_full   = (count_q == CW'(DEPTH));

  // Redirect masks the head so decode never consumes an entry about to be flushed.
  assign bus.out_valid = not_empty & ~bus.redirect_valid;
  assign bus.out_pc    = not_empty ? pc_mem[rd_ptr_q]   : 32'h0;
  assign bus.out_inst  = not_empty ? inst_mem[rd_ptr_q] : 32'h0;
  assign bus.empty     = ~not_empty;
  assign bus.full      = is_full;
  assign bus.imem_addr = fetch_pc_q;

  assign pop  = bus.out_valid & bus.out_ready;
  assign push = ~bus.redirect_valid & ~bus.halt_req & (~is_full | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      inst_mem[wr_ptr_q] <= bus.imem_dout;
    end
  end

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (push) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (bus.redirect_valid) begin
        perf_flush_q <= perf_flush_q + 32'(count_q);
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
